// File: rtl/xbar_output_arbiter_if.sv
// Bus bundle between the crossbar output arbiter and its FIFO read sides / downstream sink.
// master: the arbiter; slave: the FIFOs and the downstream consumer.
interface xbar_output_arbiter_if #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned IDX_W = $clog2(NUM_IN);

   logic [NUM_IN-1:0]        fifo_empty;
   logic [NUM_IN*DATA_W-1:0] fifo_data;
   logic [NUM_IN-1:0]        fifo_pop;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic [IDX_W-1:0]         out_src;
   logic                     out_ready;
   logic                     locked;
   logic [IDX_W-1:0]         lock_id;

   modport master (
      input  fifo_empty, fifo_data, out_ready,
      output fifo_pop, out_valid, out_data, out_src, locked, lock_id
   );

   modport slave (
      output fifo_empty, fifo_data, out_ready,
      input  fifo_pop, out_valid, out_data, out_src, locked, lock_id
   );
endinterface

// File: rtl/xbar_output_arbiter.sv
// Burst-locked round-robin arbiter sharing one crossbar output between NUM_IN FIFO read sides.
// Pops the granted FIFO into a registered valid/ready output stage.
module xbar_output_arbiter #(
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic                   clk_rx,
   input  logic                   nrst_rx,
   xbar_output_arbiter_if.master  arb
);
   localparam int unsigned IDX_W = $clog2(NUM_IN);
   localparam int unsigned CNT_W = $clog2(BURST_MAX) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  cur;
   logic [CNT_W-1:0]  beat_cnt;

   logic [IDX_W-1:0]  sel_c;
   logic              sel_vld_c;
   int unsigned       scan_idx_c;
   logic [DATA_W-1:0] cur_data_c;
   logic [IDX_W-1:0]  cur_inc_c;
   logic              load_c;
   logic              pop_c;
   logic              release_c;

   // First non-empty FIFO scanning from rr_ptr with explicit modulo wrap
   always_comb begin
      sel_vld_c  = 1'b0;
      sel_c      = '0;
      scan_idx_c = 0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         scan_idx_c = int'(rr_ptr) + k;
         if (scan_idx_c >= NUM_IN) scan_idx_c = scan_idx_c - NUM_IN;
         if (!sel_vld_c && !arb.fifo_empty[IDX_W'(scan_idx_c)]) begin
            sel_vld_c = 1'b1;
            sel_c     = IDX_W'(scan_idx_c);
         end
      end
   end

   always_comb begin
      cur_data_c = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (IDX_W'(k) == cur) cur_data_c = arb.fifo_data[k*DATA_W +: DATA_W];
      end
   end

   assign cur_inc_c = (cur == IDX_W'(NUM_IN - 1)) ? '0 : cur + IDX_W'(1);
   assign load_c    = ~arb.out_valid | arb.out_ready;
   assign pop_c     = nrst_rx & (state == GRANT) & load_c & ~arb.fifo_empty[cur];
   // Release on the last beat of a burst, or when the granted FIFO runs dry with the stage free
   assign release_c = (state == GRANT) & load_c &
                      (arb.fifo_empty[cur] | (beat_cnt == CNT_W'(BURST_MAX - 1)));

   always_comb begin
      arb.fifo_pop = '0;
      if (pop_c) arb.fifo_pop[cur] = 1'b1;
   end

   always_ff @(posedge clk_rx or negedge nrst_rx) begin
      if (!nrst_rx) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         cur           <= '0;
         beat_cnt      <= '0;
         arb.out_valid <= 1'b0;
         arb.out_data  <= '0;
         arb.out_src   <= '0;
         arb.locked    <= 1'b0;
         arb.lock_id   <= '0;
      end else begin
         // Output stage holds while a beat is stalled downstream
         if (load_c) begin
            arb.out_valid <= pop_c;
            if (pop_c) begin
               arb.out_data <= cur_data_c;
               arb.out_src  <= cur;
            end
         end

         case (state)
            IDLE: begin
               if (sel_vld_c) begin
                  state       <= GRANT;
                  cur         <= sel_c;
                  beat_cnt    <= '0;
                  arb.locked  <= 1'b1;
                  arb.lock_id <= sel_c;
               end
            end
            GRANT: begin
               if (release_c) begin
                  state      <= IDLE;
                  rr_ptr     <= cur_inc_c;
                  arb.locked <= 1'b0;
               end else if (pop_c) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Directed bench for xbar_output_arbiter: model FIFOs, a beat logger, and hand-computed expectations.
module tb_xbar_output_arbiter;
   localparam int unsigned NUM_IN    = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned BURST_MAX = 4;
   localparam int unsigned LOG_MAX   = 128;

   logic clk_rx = 1'b0;
   logic nrst_rx;

   xbar_output_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();

   xbar_output_arbiter #(
      .NUM_IN(NUM_IN), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk_rx (clk_rx),
      .nrst_rx(nrst_rx),
      .arb    (bus)
   );

   always #5 clk_rx = ~clk_rx;

   // Model FIFOs: main writes mem/wr_ptr, the pop process owns rd_ptr
   logic [DATA_W-1:0] mem [NUM_IN][64];
   logic [5:0]        wr_ptr [NUM_IN];
   logic [5:0]        rd_ptr [NUM_IN];
   logic [NUM_IN-1:0] pend;

   always_comb begin
      bus.fifo_empty = '0;
      bus.fifo_data  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         bus.fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
         bus.fifo_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
      end
   end

   initial begin
      for (int i = 0; i < NUM_IN; i++) rd_ptr[i] = 6'd0;
      pend = '0;
      forever begin
         @(negedge clk_rx);
         pend = bus.fifo_pop;
         @(posedge clk_rx);
         #1;
         for (int i = 0; i < NUM_IN; i++) if (pend[i]) rd_ptr[i] = rd_ptr[i] + 6'd1;
      end
   end

   // Beat logger and invariant watcher
   int unsigned       cyc;
   int unsigned       n_log;
   int unsigned       n_viol;
   logic [DATA_W-1:0] log_data [LOG_MAX];
   logic [1:0]        log_src  [LOG_MAX];
   int unsigned       log_cyc  [LOG_MAX];

   initial begin
      cyc = 0; n_log = 0; n_viol = 0;
      forever begin
         @(negedge clk_rx);
         cyc = cyc + 1;
         if (nrst_rx && bus.out_valid && bus.out_ready && n_log < LOG_MAX) begin
            log_data[n_log] = bus.out_data;
            log_src[n_log]  = bus.out_src;
            log_cyc[n_log]  = cyc;
            n_log = n_log + 1;
         end
         if ((bus.fifo_pop & (bus.fifo_pop - 4'd1)) != 4'd0) n_viol = n_viol + 1;
         if ((bus.fifo_pop & bus.fifo_empty) != 4'd0) n_viol = n_viol + 1;
         if (!nrst_rx && bus.fifo_pop != 4'd0) n_viol = n_viol + 1;
      end
   end

   int unsigned n_checks;
   int unsigned n_pass;
   int unsigned base;

   int unsigned gap2   [6]  = '{0, 1, 2, 3, 5, 6};
   int unsigned order3 [6]  = '{0, 2, 3, 0, 2, 3};
   int unsigned src5   [6]  = '{0, 0, 1, 1, 1, 1};
   int unsigned idx5   [6]  = '{0, 1, 0, 1, 2, 3};
   int unsigned src6   [10] = '{1, 2, 0, 0, 2, 2, 2, 2, 3, 3};
   int unsigned idx6   [10] = '{0, 0, 0, 1, 2, 3, 4, 5, 0, 1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] word(input logic [7:0] tag, input int unsigned f, input int unsigned j);
      return {tag, 8'(f), 16'(j)};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_rx);
         #1;
      end
   endtask

   task automatic load(input int unsigned f, input int unsigned n, input logic [7:0] tag);
      for (int unsigned j = 0; j < n; j++) begin
         mem[f][wr_ptr[f]] = word(tag, f, j);
         wr_ptr[f] = wr_ptr[f] + 6'd1;
      end
   endtask

   task automatic do_reset();
      nrst_rx = 1'b0;
      tick(2);
      nrst_rx = 1'b1;
   endtask

   task automatic check_beat(input string tag, input int unsigned idx,
                             input int unsigned src, input logic [31:0] data);
      check($sformatf("%s_src[%0d]", tag, idx), 32'(log_src[idx]), 32'(src));
      check($sformatf("%s_data[%0d]", tag, idx), log_data[idx], data);
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      nrst_rx = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NUM_IN; i++) wr_ptr[i] = 6'd0;

      // Reset state and idle with all FIFOs empty
      tick(3);
      check("rst_pop",     32'(bus.fifo_pop),  32'd0);
      check("rst_valid",   32'(bus.out_valid), 32'd0);
      check("rst_locked",  32'(bus.locked),    32'd0);
      check("rst_lock_id", 32'(bus.lock_id),   32'd0);
      check("rst_data",    bus.out_data,       32'd0);
      check("rst_src",     32'(bus.out_src),   32'd0);
      bus.out_ready = 1'b1;
      nrst_rx = 1'b1;
      tick(6);
      check("idle_pop",    32'(bus.fifo_pop),  32'd0);
      check("idle_valid",  32'(bus.out_valid), 32'd0);
      check("idle_locked", 32'(bus.locked),    32'd0);

      // Single burst of 6 from FIFO1: 4 back-to-back, one gap, then 2
      base = n_log;
      load(1, 6, 8'h02);
      tick(1);
      check("burst_locked",  32'(bus.locked),   32'd1);
      check("burst_lock_id", 32'(bus.lock_id),  32'd1);
      check("burst_pop",     32'(bus.fifo_pop), 32'h2);
      tick(14);
      check("burst_count", n_log - base, 32'd6);
      for (int unsigned k = 0; k < 6; k++) begin
         check_beat("burst", base + k, 1, word(8'h02, 1, k));
         check($sformatf("burst_cyc[%0d]", k), log_cyc[base + k] - log_cyc[base], gap2[k]);
      end
      check("burst_unlocked", 32'(bus.locked), 32'd0);

      // Round robin over FIFOs 0, 2, 3 with 8 words each
      do_reset();
      base = n_log;
      load(0, 8, 8'h03);
      load(2, 8, 8'h03);
      load(3, 8, 8'h03);
      tick(40);
      check("rr_count", n_log - base, 32'd24);
      for (int unsigned k = 0; k < 24; k++) begin
         check_beat("rr", base + k, order3[k / 4],
                    word(8'h03, order3[k / 4], ((k / 4) >= 3 ? 4 : 0) + (k % 4)));
      end
      for (int unsigned k = 0; k < 23; k++) begin
         check($sformatf("rr_gap[%0d]", k), log_cyc[base + k + 1] - log_cyc[base + k],
               ((k % 4) == 3) ? 32'd2 : 32'd1);
      end

      // Backpressure for 5 cycles after the 2nd beat of FIFO2
      do_reset();
      base = n_log;
      load(2, 8, 8'h04);
      tick(3);
      check("bp_data_pre", bus.out_data, word(8'h04, 2, 1));
      bus.out_ready = 1'b0;
      #1;
      check("bp_pop_drop", 32'(bus.fifo_pop), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check($sformatf("bp_data[%0d]", k),   bus.out_data,        word(8'h04, 2, 1));
         check($sformatf("bp_valid[%0d]", k),  32'(bus.out_valid),  32'd1);
         check($sformatf("bp_pop[%0d]", k),    32'(bus.fifo_pop),   32'd0);
         check($sformatf("bp_locked[%0d]", k), 32'(bus.locked),     32'd1);
      end
      bus.out_ready = 1'b1;
      tick(12);
      check("bp_count", n_log - base, 32'd8);
      for (int unsigned k = 0; k < 8; k++) check_beat("bp", base + k, 2, word(8'h04, 2, k));
      check("bp_gap23", log_cyc[base + 3] - log_cyc[base + 2], 32'd1);
      check("bp_gap34", log_cyc[base + 4] - log_cyc[base + 3], 32'd2);

      // Early empty: 2 words from FIFO0 then 4 from FIFO1
      do_reset();
      base = n_log;
      load(0, 2, 8'h05);
      load(1, 4, 8'h05);
      tick(1);
      check("ee_lock0_id", 32'(bus.lock_id), 32'd0);
      check("ee_lock0",    32'(bus.locked),  32'd1);
      tick(3);
      check("ee_release",  32'(bus.locked),  32'd0);
      tick(1);
      check("ee_lock1",    32'(bus.locked),  32'd1);
      check("ee_lock1_id", 32'(bus.lock_id), 32'd1);
      tick(8);
      check("ee_count", n_log - base, 32'd6);
      for (int unsigned k = 0; k < 6; k++) check_beat("ee", base + k, src5[k], word(8'h05, src5[k], idx5[k]));

      // Asynchronous reset during the 2nd beat of a FIFO2 burst
      do_reset();
      base = n_log;
      load(1, 1, 8'h06);
      load(2, 6, 8'h06);
      load(3, 2, 8'h06);
      tick(4);
      check("ar_lock_id", 32'(bus.lock_id), 32'd2);
      tick(2);
      check("ar_data_pre", bus.out_data, word(8'h06, 2, 1));
      nrst_rx = 1'b0;
      load(0, 2, 8'h06);
      #1;
      check("ar_pop",    32'(bus.fifo_pop),  32'd0);
      check("ar_valid",  32'(bus.out_valid), 32'd0);
      check("ar_locked", 32'(bus.locked),    32'd0);
      check("ar_data",   bus.out_data,       32'd0);
      tick(2);
      check("ar_pop_hold", 32'(bus.fifo_pop), 32'd0);
      nrst_rx = 1'b1;
      tick(1);
      check("ar_relock",    32'(bus.locked),  32'd1);
      check("ar_relock_id", 32'(bus.lock_id), 32'd0);
      tick(20);
      check("ar_count", n_log - base, 32'd10);
      for (int unsigned k = 0; k < 10; k++) check_beat("ar", base + k, src6[k], word(8'h06, src6[k], idx6[k]));

      // All FIFOs drained exactly, and no illegal pop was ever seen
      for (int i = 0; i < NUM_IN; i++) check($sformatf("drained[%0d]", i), 32'(rd_ptr[i]), 32'(wr_ptr[i]));
      check("pop_invariants", n_viol, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
